// File: rtl/register_file_sync.sv
// Register file: one write port, two registered read ports, per-register written flags and a background clear.
// Optional REGFILE_BYPASS_EN: a same-cycle write is forwarded to the reads (write-first); default is read-first.
module register_file_sync #(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 3,
    parameter int ZERO_REG  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    write_en,
    input  logic [BITS_ADDR-1:0]    dirrInput,
    input  logic [BITS_DATA-1:0]    inputData,
    input  logic                    read_en,
    input  logic [BITS_ADDR-1:0]    dirrOutput1,
    input  logic [BITS_ADDR-1:0]    dirrOutput2,
    output logic [BITS_DATA-1:0]    outputData1,
    output logic [BITS_DATA-1:0]    outputData2,
    output logic                    read_valid,
    input  logic                    clear_start,
    output logic                    busy,
    output logic [2**BITS_ADDR-1:0] written
);

    localparam int DEPTH = 2**BITS_ADDR;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t               state;
    logic [BITS_DATA-1:0] regs [DEPTH];
    logic [BITS_ADDR-1:0] clearIdx;
    logic                 writeOk;
    logic [BITS_DATA-1:0] rdData1;
    logic [BITS_DATA-1:0] rdData2;

    // Writes to register 0 are discarded when it is hardwired to zero.
    assign writeOk = write_en && !((ZERO_REG != 0) && (dirrInput == '0));

    function automatic logic [BITS_DATA-1:0] readPort(input logic [BITS_ADDR-1:0] addr);
        logic [BITS_DATA-1:0] d;
        d = regs[addr];
`ifdef REGFILE_BYPASS_EN
        if (writeOk && (addr == dirrInput))
            d = inputData;
`endif
        if ((ZERO_REG != 0) && (addr == '0))
            d = '0;
        return d;
    endfunction

    always_comb begin
        rdData1 = readPort(dirrOutput1);
        rdData2 = readPort(dirrOutput2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            clearIdx    <= '0;
            written     <= '0;
            read_valid  <= 1'b0;
            outputData1 <= '0;
            outputData2 <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else begin
            read_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    // A clear request takes priority and drops that cycle's access.
                    if (clear_start) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                    end else begin
                        if (writeOk) begin
                            regs[dirrInput]    <= inputData;
                            written[dirrInput] <= 1'b1;
                        end
                        if (read_en) begin
                            outputData1 <= rdData1;
                            outputData2 <= rdData2;
                            read_valid  <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    regs[clearIdx]    <= '0;
                    written[clearIdx] <= 1'b0;
                    clearIdx          <= clearIdx + BITS_ADDR'(1);
                    if (clearIdx == '1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_file_sync.sv
// Directed-vector bench for register_file_sync; a second instance with ZERO_REG=1 shares the stimulus.
module tb_register_file_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_en;
    logic [2:0]  dirrInput;
    logic [31:0] inputData;
    logic        read_en;
    logic [2:0]  dirrOutput1;
    logic [2:0]  dirrOutput2;
    logic        clear_start;
    logic [31:0] outputData1, outputData2, zOut1, zOut2;
    logic        read_valid, busy, zValid, zBusy;
    logic [7:0]  written, zWritten;

    int vectors     = 0;
    int miscompares = 0;

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] SAME_CYCLE_EXP = 32'h12345678;
`else
    localparam logic [31:0] SAME_CYCLE_EXP = 32'h0;
`endif

    always #5 clk = ~clk;

    register_file_sync #(.BITS_DATA(32), .BITS_ADDR(3), .ZERO_REG(0)) dut (
        .clk(clk), .rst(rst), .write_en(write_en), .dirrInput(dirrInput),
        .inputData(inputData), .read_en(read_en), .dirrOutput1(dirrOutput1),
        .dirrOutput2(dirrOutput2), .outputData1(outputData1), .outputData2(outputData2),
        .read_valid(read_valid), .clear_start(clear_start), .busy(busy), .written(written)
    );

    register_file_sync #(.BITS_DATA(32), .BITS_ADDR(3), .ZERO_REG(1)) dutZ (
        .clk(clk), .rst(rst), .write_en(write_en), .dirrInput(dirrInput),
        .inputData(inputData), .read_en(read_en), .dirrOutput1(dirrOutput1),
        .dirrOutput2(dirrOutput2), .outputData1(zOut1), .outputData2(zOut2),
        .read_valid(zValid), .clear_start(clear_start), .busy(zBusy), .written(zWritten)
    );

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        write_en    = 1'b0;
        dirrInput   = '0;
        inputData   = '0;
        read_en     = 1'b0;
        dirrOutput1 = '0;
        dirrOutput2 = '0;
        clear_start = 1'b0;
    endtask

    task automatic readAllZero(input string tag);
        for (int a = 0; a < 8; a++) begin
            read_en     = 1'b1;
            dirrOutput1 = 3'(a);
            dirrOutput2 = 3'(7 - a);
            tick();
            checkVal({tag, " out1"}, outputData1, 0);
            checkVal({tag, " out2"}, outputData2, 0);
            checkVal({tag, " rvalid"}, read_valid, 1);
        end
        read_en = 1'b0;
    endtask

    initial begin
        idleInputs();
        rst = 1'b1;
        tick();
        tick();
        checkVal("rst busy", busy, 0);
        checkVal("rst written", written, 0);
        checkVal("rst out1", outputData1, 0);
        checkVal("rst rvalid", read_valid, 0);
        rst = 1'b0;

        // 1: every address reads zero after reset
        readAllZero("t1");
        tick();
        checkVal("t1 rvalid low", read_valid, 0);
        checkVal("t1 written", written, 8'h00);
        checkVal("t1 busy", busy, 0);

        // 2: write then read on the next cycle
        write_en = 1'b1; dirrInput = 3'd3; inputData = 32'hDEADBEEF;
        tick();
        write_en = 1'b0;
        read_en = 1'b1; dirrOutput1 = 3'd3; dirrOutput2 = 3'd0;
        tick();
        checkVal("t2 out1", outputData1, 32'hDEADBEEF);
        checkVal("t2 out2", outputData2, 0);
        checkVal("t2 rvalid", read_valid, 1);
        checkVal("t2 written", written, 8'h08);
        read_en = 1'b0;
        tick();
        checkVal("t2 rvalid pulse", read_valid, 0);
        checkVal("t2 hold", outputData1, 32'hDEADBEEF);

        // 3: same-cycle write and read of R5 on both ports
        write_en = 1'b1; dirrInput = 3'd5; inputData = 32'h12345678;
        read_en = 1'b1; dirrOutput1 = 3'd5; dirrOutput2 = 3'd5;
        tick();
        checkVal("t3 same out1", outputData1, SAME_CYCLE_EXP);
        checkVal("t3 same out2", outputData2, SAME_CYCLE_EXP);
        checkVal("t3 written", written, 8'h28);
        write_en = 1'b0;
        tick();
        checkVal("t3 next out1", outputData1, 32'h12345678);
        checkVal("t3 next out2", outputData2, 32'h12345678);
        read_en = 1'b0;

        // 4: fill, clear, and writes/reads ignored while busy
        for (int a = 0; a < 8; a++) begin
            write_en = 1'b1; dirrInput = 3'(a); inputData = 32'(a + 1);
            tick();
        end
        write_en = 1'b0;
        checkVal("t4 written full", written, 8'hFF);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        checkVal("t4 busy start", busy, 1);
        write_en = 1'b1; dirrInput = 3'd2; inputData = 32'hAA;
        read_en = 1'b1; dirrOutput1 = 3'd2; dirrOutput2 = 3'd2;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checkVal($sformatf("t4 busy %0d", i), busy, (i < 8) ? 1 : 0);
            checkVal("t4 rvalid in clear", read_valid, 0);
            checkVal("t4 hold in clear", outputData1, 32'h12345678);
        end
        idleInputs();
        checkVal("t4 written cleared", written, 8'h00);
        readAllZero("t4");
        checkVal("t4 written after", written, 8'h00);

        // 5: ZERO_REG instance discards R0 writes, plain instance keeps them
        write_en = 1'b1; dirrInput = 3'd0; inputData = 32'hFFFFFFFF;
        tick();
        read_en = 1'b1; dirrOutput1 = 3'd0; dirrOutput2 = 3'd0;
        tick();
        checkVal("t5 z out1", zOut1, 0);
        checkVal("t5 z out2", zOut2, 0);
        checkVal("t5 z written", zWritten, 8'h00);
        checkVal("t5 plain out1", outputData1, 32'hFFFFFFFF);
        checkVal("t5 plain written", written, 8'h01);
        tick();
        checkVal("t5 z same-cycle", zOut1, 0);
        write_en = 1'b0; read_en = 1'b0;

        // 6: reset aborts a clear in progress
        for (int a = 1; a < 8; a++) begin
            write_en = 1'b1; dirrInput = 3'(a); inputData = 32'h100 + 32'(a);
            tick();
        end
        write_en = 1'b0;
        checkVal("t6 written", written, 8'hFF);
        checkVal("t6 z written", zWritten, 8'hFE);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        tick();
        tick();
        checkVal("t6 busy pre-rst", busy, 1);
        checkVal("t6 out1 pre-rst", outputData1, 32'hFFFFFFFF);
        rst = 1'b1;
        #2;
        checkVal("t6 async busy", busy, 0);
        checkVal("t6 async out1", outputData1, 0);
        checkVal("t6 async out2", outputData2, 0);
        checkVal("t6 async written", written, 0);
        tick();
        rst = 1'b0;
        readAllZero("t6");
        checkVal("t6 busy after", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
